// File: rtl/spi_sram_master.sv
// SPI mode-0 master for a serial SRAM: 8-bit address phase then 8-bit data phase.
// Optional readback of the data phase is enabled by defining SPI_READBACK_EN.
module spi_sram_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sck,
  output logic       sdo,
  input  logic       sdi,
  output logic       la_n,
  output logic       da_n
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic [15:0] tx;

  logic accept;
  logic half_end;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign half_end = (div_cnt == DIV_LAST);

`ifdef SPI_READBACK_EN
  logic       rd_frame;
  logic [7:0] rx;
  logic [7:0] rdata_q;

  assign rdata = rdata_q;
`else
  logic unused_inputs;

  assign rdata         = 8'h00;
  assign unused_inputs = &{1'b0, rw, sdi};
`endif

  // tx holds the whole 16-bit frame; sdo is reloaded from tx[14] on every sck fall
  // so it only ever changes while sck is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      div_cnt <= 8'd0;
      tx      <= 16'h0000;
      sck     <= 1'b0;
      sdo     <= 1'b0;
      la_n    <= 1'b1;
      da_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_frame <= 1'b0;
      rx       <= 8'h00;
      rdata_q  <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            div_cnt <= 8'd0;
            sck     <= 1'b0;
            sdo     <= addr[7];
            la_n    <= 1'b0;
            da_n    <= 1'b1;
            busy    <= 1'b1;
`ifdef SPI_READBACK_EN
            tx       <= {addr, rw ? 8'h00 : wdata};
            rd_frame <= rw;
`else
            tx       <= {addr, wdata};
`endif
          end else begin
            state <= IDLE;
          end
        end

        ADDR, DATA: begin
          if (!half_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!sck) begin
              sck <= 1'b1;
`ifdef SPI_READBACK_EN
              if (state == DATA) rx <= {rx[6:0], sdi};
`endif
            end else begin
              sck <= 1'b0;
              tx  <= {tx[14:0], 1'b0};
              if (bit_cnt != 4'd7) begin
                bit_cnt <= bit_cnt + 4'd1;
                sdo     <= tx[14];
              end else begin
                bit_cnt <= 4'd0;
                if (state == ADDR) begin
                  state <= DATA;
                  sdo   <= tx[14];
                  la_n  <= 1'b1;
                  da_n  <= 1'b0;
                end else begin
                  state <= DONE;
                  sdo   <= 1'b0;
                  da_n  <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef SPI_READBACK_EN
                  if (rd_frame) rdata_q <= rx;
`endif
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_master.sv
// Self-checking bench for spi_sram_master: vector table, random frames against a
// frame-level model, plus reset, back-to-back and CLK_DIV=1 sequences.
module tb_spi_sram_master;

  localparam int DIV = 4;
`ifdef SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  slave;
    logic [15:0] exp_stream;
    logic [7:0]  exp_rdata;
    bit          chain;
    bit          inject;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, rw = 1'b0, sdi = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic busy, done, sck, sdo, la_n, da_n;
  logic [7:0] rdata;

  logic start1 = 1'b0;
  logic [7:0] addr1 = 8'h00, wdata1 = 8'h00;
  logic busy1, done1, sck1, sdo1, la_n1, da_n1;
  logic [7:0] rdata1;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] slave_byte = 8'h00;
  int data_rises = 0;
  logic [7:0] model_rdata = 8'h00;
  vec_t vecs[6];

  always #5 clk = ~clk;

  spi_sram_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sck(sck), .sdo(sdo), .sdi(sdi),
    .la_n(la_n), .da_n(da_n)
  );

  spi_sram_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rw(1'b0), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1), .sck(sck1), .sdo(sdo1), .sdi(1'b0),
    .la_n(la_n1), .da_n(da_n1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: what goes on the wire and what rdata becomes afterwards.
  function automatic logic [15:0] model_stream(input logic r, input logic [7:0] a, input logic [7:0] d);
    return {a, (READBACK && r) ? 8'h00 : d};
  endfunction

  function automatic logic [7:0] model_next_rdata(input logic r, input logic [7:0] s, input logic [7:0] prev);
    return (READBACK && r) ? s : prev;
  endfunction

  // Called right after the acceptance edge; watches the frame until done or timeout.
  task automatic check_output(input vec_t v);
    int cyc, rises, last_rise, done_cyc, busy_err, sdo_err, period_err;
    logic prev_sck, prev_sdo;
    logic [15:0] stream, la_low, da_low;
    logic [7:0] sh;
    bit got_done;
    rises = 0; last_rise = 0; done_cyc = -1; busy_err = 0; sdo_err = 0; period_err = 0;
    prev_sck = 1'b0; prev_sdo = 1'b0; stream = '0; la_low = '0; da_low = '0;
    got_done = 1'b0;
    for (cyc = 1; cyc <= 32 * DIV + 8 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc == 1)
        check("first_cycle", 32'({la_n, busy, sck, sdo}), 32'({1'b0, 1'b1, 1'b0, v.addr[7]}));
      if (v.inject && cyc == 40) begin
        start = 1'b1; addr = ~v.addr; wdata = ~v.wdata; rw = ~v.rw;
      end else if (v.inject && cyc == 41) begin
        start = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        if (!busy) busy_err++;
        if (sck && (sdo != prev_sdo) && cyc > 1) sdo_err++;
        if (sck && !prev_sck) begin
          stream = {stream[14:0], sdo};
          la_low = {la_low[14:0], ~la_n};
          da_low = {da_low[14:0], ~da_n};
          if (rises > 0 && (cyc - last_rise) != 2 * DIV) period_err++;
          last_rise = cyc;
          if (!da_n) data_rises++;
          rises++;
        end
      end
      prev_sck = sck;
      prev_sdo = sdo;
      sh = slave_byte << data_rises;
      sdi = sh[7];
    end
    check("done_latency", 32'(done_cyc), 32'(1 + 32 * DIV));
    if (got_done) begin
      check("done_cycle_outputs", 32'({busy, sck, la_n, da_n, sdo}), 32'(5'b00110));
      check("rdata", 32'(rdata), 32'(v.exp_rdata));
    end
    check("sdo_stream", 32'(stream), 32'(v.exp_stream));
    check("la_n_window", 32'(la_low), 32'(16'hFF00));
    check("da_n_window", 32'(da_low), 32'(16'h00FF));
    check("sck_rises", 32'(rises), 32'(16));
    check("sck_period", 32'(period_err), 32'(0));
    check("busy_in_frame", 32'(busy_err), 32'(0));
    check("sdo_stable_high", 32'(sdo_err), 32'(0));
  endtask

  task automatic apply_stimulus(input vec_t v);
    rw = v.rw; addr = v.addr; wdata = v.wdata;
    slave_byte = v.slave;
    data_rises = 0;
    sdi = v.slave[7];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_output(v);
  endtask

  initial begin
    vec_t v;
    int rc;
    vecs[0] = '{1'b0, 8'hFD, 8'hBD, 8'h00, 16'hFDBD, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hFD, 8'h11, 8'hA5, READBACK ? 16'hFD00 : 16'hFD11,
                READBACK ? 8'hA5 : 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h5A, 8'hC3, 8'hFF, 16'h5AC3, READBACK ? 8'hA5 : 8'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h01, 8'h3C, 8'h96, READBACK ? 16'h0100 : 16'h013C,
                READBACK ? 8'h96 : 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 8'h01, 8'h00, 16'h8001, READBACK ? 8'h96 : 8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'h5A, 16'h00FF, READBACK ? 8'h96 : 8'h00, 1'b0, 1'b0};

    #23;
    check("reset_outputs", 32'({sck, sdo, la_n, da_n, busy, done, rdata}), 32'({6'b001100, 8'h00}));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (!vecs[i].chain) @(negedge clk);
      apply_stimulus(vecs[i]);
      model_rdata = vecs[i].exp_rdata;
    end

    for (int i = 0; i < 10; i++) begin
      v.rw     = 1'($urandom_range(0, 1));
      v.addr   = 8'($urandom);
      v.wdata  = 8'($urandom);
      v.slave  = 8'($urandom);
      v.chain  = (i > 0) && ($urandom_range(0, 1) == 1);
      v.inject = ($urandom_range(0, 3) == 0);
      v.exp_stream = model_stream(v.rw, v.addr, v.wdata);
      v.exp_rdata  = model_next_rdata(v.rw, v.slave, model_rdata);
      if (!v.chain) @(negedge clk);
      apply_stimulus(v);
      model_rdata = v.exp_rdata;
    end

    // Reset dropped in during address bit 5 must abort silently.
    @(negedge clk);
    rw = 1'b0; addr = 8'hFD; wdata = 8'hBD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (44) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_idle", 32'({sck, sdo, la_n, da_n, busy, done, rdata}), 32'({6'b001100, 8'h00}));
    rc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) rc++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) rc++;
    end
    check("no_done_after_reset", 32'(rc), 32'(0));
    model_rdata = 8'h00;
    v = '{1'b0, 8'h12, 8'h34, 8'h00, 16'h1234, 8'h00, 1'b0, 1'b0};
    apply_stimulus(v);

    // Fastest divider: one clk per sck half period.
    @(negedge clk);
    addr1 = 8'hC3; wdata1 = 8'h5A; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    begin
      int dcyc, r1;
      logic p1;
      logic [15:0] s1;
      dcyc = -1; r1 = 0; p1 = 1'b0; s1 = '0;
      for (int c = 1; c <= 40 && dcyc < 0; c++) begin
        @(negedge clk);
        if (done1) begin
          dcyc = c;
          check("div1_done_outputs", 32'({busy1, la_n1, da_n1, rdata1}), 32'({3'b011, 8'h00}));
        end else if (sck1 && !p1) begin
          s1 = {s1[14:0], sdo1};
          r1++;
        end
        p1 = sck1;
      end
      check("div1_done_latency", 32'(dcyc), 32'(33));
      check("div1_rises", 32'(r1), 32'(16));
      check("div1_stream", 32'(s1), 32'(16'hC35A));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
